// File: rtl/ysyx_23060201_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC and FSM state encoding.
// The optional misaligned-dnpc trap is controlled by YSYX_23060201_IFU_MISALIGN_CHK_EN.
package ysyx_23060201_ifu_pkg;

    localparam logic [31:0] YSYX_23060201_RESET_PC = 32'h8000_0000;
    localparam int          YSYX_23060201_XLEN     = 32;

    typedef enum logic [2:0] {
        IFU_FETCH = 3'd0,
        IFU_WAIT  = 3'd1,
        IFU_HOLD  = 3'd2,
        IFU_EXEC  = 3'd3,
        IFU_FAULT = 3'd4
    } ifu_state_e;

    // Clear the two low bits so a loaded PC is always word-aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ysyx_23060201_ifu_pc.sv
// Architectural PC register: synchronous reset to RESET_PC, loads load_val when load_en.
module ysyx_23060201_ifu_pc
    import ysyx_23060201_ifu_pkg::*;
#(
    parameter int              XLEN     = YSYX_23060201_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = YSYX_23060201_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_val,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch unit: FETCH -> WAIT -> HOLD -> EXEC, one instruction in flight.
// Define YSYX_23060201_IFU_MISALIGN_CHK_EN to trap misaligned dnpc into a sticky FAULT state.
module ysyx_23060201_ifu
    import ysyx_23060201_ifu_pkg::*;
#(
    parameter int              XLEN     = YSYX_23060201_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = YSYX_23060201_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            exu_done,
    input  logic [XLEN-1:0] dnpc,
    output logic [XLEN-1:0] pc,
    output logic            fetch_fault
);

    ifu_state_e      state_q, state_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            pc_load;
    logic [XLEN-1:0] pc_load_val;
    logic [XLEN-1:0] pc_cur;
    logic            misaligned;

    assign misaligned = (dnpc[1:0] != 2'b00);

    ysyx_23060201_ifu_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_en  (pc_load),
        .load_val (pc_load_val),
        .pc       (pc_cur)
    );

`ifdef YSYX_23060201_IFU_MISALIGN_CHK_EN
    logic fault_q, fault_d;
`endif

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        pc_load     = 1'b0;
`ifdef YSYX_23060201_IFU_MISALIGN_CHK_EN
        pc_load_val = dnpc;
        fault_d     = fault_q;
`else
        // Without the trap a misaligned target is silently rounded down.
        pc_load_val = dnpc & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif
        case (state_q)
            IFU_FETCH: begin
                if (imem_req_ready) begin
                    state_d = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_d    = imem_rsp_data;
                    inst_pc_d = pc_cur;
                    state_d   = IFU_HOLD;
                end
            end
            IFU_HOLD: begin
                if (inst_ready) begin
                    state_d = IFU_EXEC;
                end
            end
            IFU_EXEC: begin
                if (exu_done) begin
`ifdef YSYX_23060201_IFU_MISALIGN_CHK_EN
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = IFU_FAULT;
                    end else begin
                        pc_load = 1'b1;
                        state_d = IFU_FETCH;
                    end
`else
                    pc_load = 1'b1;
                    state_d = IFU_FETCH;
`endif
                end
            end
            IFU_FAULT: begin
                state_d = IFU_FAULT;
            end
            default: begin
                state_d = IFU_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IFU_FETCH;
            inst_q    <= 32'd0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef YSYX_23060201_IFU_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    // Outputs decode directly from flops, so they carry no combinational input paths.
    assign imem_req_valid = (state_q == IFU_FETCH);
    assign imem_addr      = pc_cur;
    assign inst_valid     = (state_q == IFU_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign pc             = pc_cur;

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Transaction-level bench for ysyx_23060201_ifu: each step is a fetch/decode/execute round trip.
module tb_ysyx_23060201_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        exu_done;
    logic [31:0] dnpc;
    logic [31:0] pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_pc;
    logic        model_fault;
    logic        trap_enabled;

    always #5 clk = ~clk;

    ysyx_23060201_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .exu_done       (exu_done),
        .dnpc           (dnpc),
        .pc             (pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full instruction step; stalls are inserted and stray strobes thrown at the
    // DUT in states where they must be ignored.
    task automatic run_step(input logic [31:0] data, input logic [31:0] nxt,
                            input int req_stall, input int rsp_lat,
                            input int acc_stall, input int exu_lat);
        for (int i = 0; i < req_stall; i++) begin
            check("fetch_stall_req_valid", imem_req_valid, 1);
            check("fetch_stall_addr", imem_addr, model_pc);
            check("fetch_stall_pc", pc, model_pc);
            imem_req_ready = 1'b0;
            exu_done       = 1'($urandom_range(0, 1));
            dnpc           = $urandom;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            tick();
        end
        check("fetch_req_valid", imem_req_valid, 1);
        check("fetch_addr", imem_addr, model_pc);
        check("fetch_inst_valid", inst_valid, 0);
        imem_req_ready = 1'b1;
        exu_done       = 1'($urandom_range(0, 1));
        dnpc           = $urandom;
        imem_rsp_valid = 1'($urandom_range(0, 1));
        imem_rsp_data  = $urandom;
        tick();
        for (int i = 0; i <= rsp_lat; i++) begin
            check("wait_req_valid", imem_req_valid, 0);
            check("wait_inst_valid", inst_valid, 0);
            imem_req_ready = 1'($urandom_range(0, 1));
            exu_done       = 1'($urandom_range(0, 1));
            dnpc           = $urandom;
            imem_rsp_valid = (i == rsp_lat);
            imem_rsp_data  = (i == rsp_lat) ? data : $urandom;
            tick();
        end
        for (int i = 0; i <= acc_stall; i++) begin
            check("hold_inst_valid", inst_valid, 1);
            check("hold_inst", inst, data);
            check("hold_inst_pc", inst_pc, model_pc);
            check("hold_req_valid", imem_req_valid, 0);
            check("hold_pc", pc, model_pc);
            inst_ready     = (i == acc_stall);
            imem_req_ready = 1'($urandom_range(0, 1));
            exu_done       = 1'($urandom_range(0, 1));
            dnpc           = $urandom;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            tick();
        end
        for (int i = 0; i <= exu_lat; i++) begin
            check("exec_inst_valid", inst_valid, 0);
            check("exec_req_valid", imem_req_valid, 0);
            check("exec_pc", pc, model_pc);
            inst_ready     = 1'b0;
            exu_done       = (i == exu_lat);
            dnpc           = (i == exu_lat) ? nxt : $urandom;
            imem_req_ready = 1'($urandom_range(0, 1));
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            tick();
        end
        exu_done       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        if (trap_enabled && nxt[1:0] != 2'b00) begin
            model_fault = 1'b1;
        end else begin
            model_pc = {nxt[31:2], 2'b00};
        end
        check("step_fault", fetch_fault, model_fault);
        check("step_pc", pc, model_pc);
        check("step_req_valid", imem_req_valid, !model_fault);
        check("step_addr", imem_addr, model_pc);
        check("step_inst_valid", inst_valid, 0);
    endtask

    initial begin
`ifdef YSYX_23060201_IFU_MISALIGN_CHK_EN
        trap_enabled = 1'b1;
`else
        trap_enabled = 1'b0;
`endif
        model_pc       = 32'h8000_0000;
        model_fault    = 1'b0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        inst_ready     = 1'b0;
        exu_done       = 1'b0;
        dnpc           = 32'h0;
        repeat (3) tick();

        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_fault", fetch_fault, 0);
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;

        run_step(32'h0000_0013, 32'h8000_0004, 0, 0, 0, 0);
        run_step($urandom, 32'h8000_0008, 3, 0, 0, 0);
        run_step($urandom, 32'h8000_000C, 0, 1, 5, 0);
        run_step($urandom, 32'h8000_0100, 2, 2, 2, 3);
        run_step($urandom, model_pc, 0, 0, 0, 1);
        run_step($urandom, 32'hFFFF_FFFC, 1, 0, 1, 0);
        run_step($urandom, 32'h0000_0000, 0, 1, 0, 2);
        for (int s = 0; s < 12; s++) begin
            run_step($urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while waiting for a response that lands in the reset cycle.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst            = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        model_pc       = 32'h8000_0000;
        check("midrst_pc", pc, 32'h8000_0000);
        check("midrst_inst", inst, 32'h0);
        check("midrst_inst_pc", inst_pc, 32'h0);
        check("midrst_inst_valid", inst_valid, 0);
        check("midrst_req_valid", imem_req_valid, 1);

        run_step($urandom, 32'h8000_0006, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("post_mis_req_valid", imem_req_valid, !model_fault);
            check("post_mis_pc", pc, model_pc);
            check("post_mis_fault", fetch_fault, model_fault);
            check("post_mis_inst_valid", inst_valid, 0);
            tick();
        end
        if (!model_fault) begin
            run_step($urandom, 32'h8000_0010, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
